wrr_arbiter: RTL and testbench
==============================

# wrr_arbiter

Weighted round-robin arbiter: the parametrised successor to the single-grant round-robin arbiter in the arbitration library. Each requester holds the grant for up to `weight` accepted transfers (a burst) before priority rotates. Grants are consumed through an `accept` handshake, so grants stay stable under downstream backpressure. It sits in front of shared buses and memory ports where requesters need unequal bandwidth shares.

## Interface

**Parameters**
- `WIDTH`, default 4: number of requesters; must be ≥ 2.
- `WEIGHT_W`, default 4: bit width of each per-requester weight.

**Ports**
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `req`  in  WIDTH: request vector; bit i is requester i.
- `weight`  in  WIDTH*WEIGHT_W: packed weights; requester i uses bits [i*WEIGHT_W +: WEIGHT_W]. A value of 0 is treated as 1.
- `accept`  in  1: downstream consumes the current grant this cycle.
- `grant`  out  WIDTH: one-hot grant, or all zeros.
- `grant_idx`  out  $clog2(WIDTH): binary index of `grant`; 0 when no grant.
- `grant_valid`  out  1: equals |grant.
- `burst_last`  out  1: the current grant, if accepted, consumes the owner's last credit.

## Operation

**State registers**
- `state`: IDLE or HOLD.
- `owner`: index of the requester that received the last new pick.
- `cnt`: WEIGHT_W bits, remaining credits of the owner.
- `mask`: WIDTH bits, set to the bits strictly above the last selected index.

**Effective weight**
- eff_w(i) = max(weight[i], 1).
- Weight is sampled only when a new pick is accepted. Changing the weight mid-burst does not affect the burst in progress.

**Grant selection (combinational)**
- In HOLD with `req[owner]` = 1: grant = owner.
- Otherwise, round-robin pick:
  - The lowest set bit of `req & mask`.
  - If that is zero, the lowest set bit of `req` (wrap-around).
- `req` = 0: grant = 0, grant_valid = 0, burst_last = 0.

**Transitions on a rising edge with `grant_valid && accept`**
- HOLD, owner granted:
  - cnt ← cnt − 1.
  - If cnt was 1: state ← IDLE and mask ← bits above owner.
- New pick i:
  - owner ← i and mask ← bits above i.
  - If eff_w(i) = 1: state stays or becomes IDLE.
  - Else: state ← HOLD and cnt ← eff_w(i) − 1.

**No accept**
- With `grant_valid && !accept`, no register changes.
- `grant` stays stable for as long as `req` is stable.

**Owner drop**
- In HOLD with `req[owner]` = 0, the owner forfeits its remaining credits.
- In that same cycle the round-robin pick over the other requesters applies, starting above owner.
- At the edge: state ← IDLE. If that pick is also accepted, the new-pick rule takes effect instead.

**burst_last**
- Set to 1 when (HOLD, owner granted, cnt = 1) or (new pick i with eff_w(i) = 1).
- Set to 0 otherwise.

**Edge cases**
- Mask wrap: owner = WIDTH−1 makes mask = 0, so the next pick is the lowest requesting index.
- Single requester: a requester that is the only one requesting is re-picked immediately after its burst ends; there is no idle cycle.

## Timing

- Grant latency is zero: `grant`, `grant_idx`, `grant_valid` and `burst_last` are combinational from `req`, `weight` and registered state.
- Register updates become visible in the cycle after the accepting edge.

**Reset**
- At a rising edge with `rst` = 1: state ← IDLE, owner ← 0, cnt ← 0, mask ← all ones.
- `rst` has priority over `accept`.
- While `rst` is high, all outputs are forced to 0.
- Reset mid-burst discards the burst. The first grant after reset goes to the lowest requesting index.

**Throughput**
- One accepted grant per cycle.
- No bubble cycles between bursts or at wrap-around.

**Width rules**
- cnt never underflows: decrement happens only when cnt ≥ 1 in HOLD.
- eff_w − 1 fits in WEIGHT_W bits.

## Test plan

All scenarios use WIDTH = 4, WEIGHT_W = 4. Each assertion is sampled 1 ns after inputs change after the rising edge.

1. **Plain round-robin.** Reset for 3 cycles, all weights 1, req = 1111, accept = 1 → grant 0001, 0010, 0100, 1000, 0001; burst_last = 1 every cycle.
2. **Weighted sequence.** Weights {w0=3, w1=1, w2=2, w3=1}, req = 1111, accept = 1 → grant 0001, 0001, 0001, 0010, 0100, 0100, 1000, 0001; burst_last = 1 on grants 3, 4, 6, 7.
3. **Backpressure.** w0 = 2, req = 1111, accept pattern 1, 0, 0, 1 → grant 0001 for all 4 cycles (cnt decrements only on accepted cycles); the next grant is 0010.
4. **Owner drop.** w0 = 3, req = 1111, one accepted grant 0001, then req = 1110 in the same cycle → grant 0010 immediately; the next grant after that is 0100.
5. **Zero weight and wrap.** w3 = 0, req = 1000, accept = 1 → grant 1000 every cycle with burst_last = 1. Then req = 1001 → grant 0001 (wrap-around).
6. **Reset mid-burst.** w2 = 3, owner 2 in HOLD with cnt = 2, assert rst for 1 cycle (outputs read 0000) → after release, req = 1111 gives grant 0001.

Source files
------------

// File: rtl/wrr_arbiter.sv
// wrr_arbiter: weighted round-robin arbiter; each requester keeps the grant for up to weight accepted transfers
module wrr_arbiter #(
  parameter int WIDTH = 4,
  parameter int WEIGHT_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          req,
  input  logic [WIDTH*WEIGHT_W-1:0] weight,
  input  logic                      accept,
  output logic [WIDTH-1:0]          grant,
  output logic [$clog2(WIDTH)-1:0]  grant_idx,
  output logic                      grant_valid,
  output logic                      burst_last
);
  localparam int IW = $clog2(WIDTH);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t              state;
  logic [IW-1:0]       owner, pick;
  logic [WEIGHT_W-1:0] cnt, pick_w;
  logic [WIDTH-1:0]    mask;
  logic                hold_hit, pick_one;
  function automatic logic [IW-1:0] lowest(input logic [WIDTH-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int j = WIDTH - 1; j >= 0; j--) if (v[j]) r = IW'(j);
    return r;
  endfunction
  function automatic logic [WIDTH-1:0] above(input logic [IW-1:0] i);
    logic [WIDTH-1:0] r;
    for (int j = 0; j < WIDTH; j++) r[j] = j > int'(i);
    return r;
  endfunction
  always_comb begin
    hold_hit = state == HOLD && req[owner];
    pick = (req & mask) != '0 ? lowest(req & mask) : lowest(req);
    pick_w = weight[pick*WEIGHT_W +: WEIGHT_W];
    pick_one = pick_w <= WEIGHT_W'(1);
    grant_valid = !rst && req != '0;
    grant_idx = !grant_valid ? '0 : hold_hit ? owner : pick;
    grant = grant_valid ? WIDTH'(1) << grant_idx : '0;
    burst_last = grant_valid && (hold_hit ? cnt == WEIGHT_W'(1) : pick_one);
  end
  // an owner that stops requesting forfeits its credits even without an accept
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      cnt <= '0;
      mask <= '1;
    end else if (grant_valid && accept) begin
      if (hold_hit) begin
        cnt <= cnt - 1'b1;
        if (cnt == WEIGHT_W'(1)) begin
          state <= IDLE;
          mask <= above(owner);
        end
      end else begin
        owner <= pick;
        mask <= above(pick);
        state <= pick_one ? IDLE : HOLD;
        cnt <= pick_one ? cnt : pick_w - 1'b1;
      end
    end else if (state == HOLD && !req[owner]) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_wrr_arbiter.sv
// tb_wrr_arbiter: directed scenario tasks for wrr_arbiter with WIDTH=4, WEIGHT_W=4
module tb_wrr_arbiter;
  logic        clk = 0;
  logic        rst = 1;
  logic [3:0]  req = '0;
  logic [15:0] weight = 16'h1111;
  logic        accept = 0;
  logic [3:0]  grant;
  logic [1:0]  grant_idx;
  logic        grant_valid, burst_last;
  int n_cmp = 0;
  int n_err = 0;
  wrr_arbiter #(.WIDTH(4), .WEIGHT_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .weight(weight), .accept(accept),
    .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid), .burst_last(burst_last)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input int n);
    rst = 1;
    repeat (n) tick();
    rst = 0;
  endtask
  task automatic test_reset();
    rst = 1; req = 4'b1111; accept = 1; weight = 16'h1111;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if ({grant, grant_idx, grant_valid, burst_last} !== 8'h00) begin
        n_err++;
        $display("FAIL reset_out[%0d] got grant=%b idx=%0d v=%b bl=%b want all 0", k, grant, grant_idx, grant_valid, burst_last);
      end
    end
    rst = 0;
    #1;
    n_cmp++;
    if (grant !== 4'b0001 || grant_idx !== 2'd0) begin
      n_err++;
      $display("FAIL reset_first got grant=%b idx=%0d want 0001 idx 0", grant, grant_idx);
    end
  endtask
  task automatic test_round_robin();
    logic [3:0] eg [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] ei [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    weight = 16'h1111; req = 4'b1111; accept = 1;
    do_reset(3);
    #1;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (grant !== eg[k] || grant_idx !== ei[k] || burst_last !== 1'b1 || grant_valid !== 1'b1) begin
        n_err++;
        $display("FAIL rr[%0d] got grant=%b idx=%0d bl=%b v=%b want %b idx %0d bl 1 v 1", k, grant, grant_idx, burst_last, grant_valid, eg[k], ei[k]);
      end
      tick();
    end
  endtask
  task automatic test_weighted();
    logic [3:0] eg [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b0001};
    logic       eb [8] = '{0, 0, 1, 1, 0, 1, 1, 0};
    weight = {4'd1, 4'd2, 4'd1, 4'd3}; req = 4'b1111; accept = 1;
    do_reset(1);
    #1;
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (grant !== eg[k] || burst_last !== eb[k]) begin
        n_err++;
        $display("FAIL weighted[%0d] got grant=%b bl=%b want %b bl %b", k, grant, burst_last, eg[k], eb[k]);
      end
      tick();
    end
  endtask
  task automatic test_backpressure();
    logic       ea [5] = '{1, 0, 0, 1, 1};
    logic [3:0] eg [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    logic       eb [5] = '{0, 1, 1, 1, 1};
    weight = {4'd1, 4'd1, 4'd1, 4'd2}; req = 4'b1111;
    do_reset(1);
    for (int k = 0; k < 5; k++) begin
      accept = ea[k];
      #1;
      n_cmp++;
      if (grant !== eg[k] || burst_last !== eb[k]) begin
        n_err++;
        $display("FAIL backpressure[%0d] got grant=%b bl=%b want %b bl %b", k, grant, burst_last, eg[k], eb[k]);
      end
      tick();
    end
  endtask
  task automatic test_owner_drop();
    weight = {4'd1, 4'd1, 4'd1, 4'd3}; req = 4'b1111; accept = 1;
    do_reset(1);
    #1;
    n_cmp++;
    if (grant !== 4'b0001 || burst_last !== 1'b0) begin
      n_err++;
      $display("FAIL drop_first got grant=%b bl=%b want 0001 bl 0", grant, burst_last);
    end
    tick();
    req = 4'b1110;
    #1;
    n_cmp++;
    if (grant !== 4'b0010 || grant_idx !== 2'd1 || burst_last !== 1'b1) begin
      n_err++;
      $display("FAIL drop_switch got grant=%b idx=%0d bl=%b want 0010 idx 1 bl 1", grant, grant_idx, burst_last);
    end
    tick();
    n_cmp++;
    if (grant !== 4'b0100) begin
      n_err++;
      $display("FAIL drop_next got grant=%b want 0100", grant);
    end
  endtask
  task automatic test_zero_weight_wrap();
    weight = {4'd0, 4'd1, 4'd1, 4'd1}; req = 4'b0000; accept = 1;
    do_reset(1);
    #1;
    n_cmp++;
    if ({grant, grant_idx, grant_valid, burst_last} !== 8'h00) begin
      n_err++;
      $display("FAIL no_req got grant=%b idx=%0d v=%b bl=%b want all 0", grant, grant_idx, grant_valid, burst_last);
    end
    req = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (grant !== 4'b1000 || grant_idx !== 2'd3 || burst_last !== 1'b1) begin
        n_err++;
        $display("FAIL zero_w[%0d] got grant=%b idx=%0d bl=%b want 1000 idx 3 bl 1", k, grant, grant_idx, burst_last);
      end
      tick();
    end
    req = 4'b1001;
    #1;
    n_cmp++;
    if (grant !== 4'b0001 || grant_idx !== 2'd0) begin
      n_err++;
      $display("FAIL wrap got grant=%b idx=%0d want 0001 idx 0", grant, grant_idx);
    end
  endtask
  task automatic test_reset_mid_burst();
    weight = {4'd1, 4'd3, 4'd1, 4'd1}; req = 4'b0100; accept = 1;
    do_reset(1);
    #1;
    n_cmp++;
    if (grant !== 4'b0100 || burst_last !== 1'b0) begin
      n_err++;
      $display("FAIL mid_pick got grant=%b bl=%b want 0100 bl 0", grant, burst_last);
    end
    tick();
    rst = 1; req = 4'b1111;
    #1;
    n_cmp++;
    if ({grant, grant_valid, burst_last} !== 6'h00) begin
      n_err++;
      $display("FAIL mid_rst got grant=%b v=%b bl=%b want 0000 0 0", grant, grant_valid, burst_last);
    end
    tick();
    rst = 0;
    #1;
    n_cmp++;
    if (grant !== 4'b0001 || burst_last !== 1'b1) begin
      n_err++;
      $display("FAIL mid_after got grant=%b bl=%b want 0001 bl 1", grant, burst_last);
    end
  endtask
  initial begin
    test_reset();
    test_round_robin();
    test_weighted();
    test_backpressure();
    test_owner_drop();
    test_zero_weight_wrap();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
